// File: rtl/ex_stage_pipe.sv
// Registered RV32I/RV64I execute stage: ALU, branch/jump resolution, iterative MUL,
// EX/MEM output register with valid/ready handshakes on both sides.
module ex_stage_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_EN  = 1,
  parameter int unsigned MUL_BPC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_npc,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [XLEN-1:0] in_imm,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_alu,
  output logic [XLEN-1:0] out_store,
  output logic [31:0]     out_ir,
  output logic [XLEN-1:0] out_pc_next,
  output logic [1:0]      out_exc,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  localparam int unsigned SHW     = $clog2(XLEN);
  localparam int unsigned MUL_CYC = XLEN / MUL_BPC;
  localparam int unsigned CW      = $clog2(MUL_CYC + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [1:0]      state_q, state_d;
  logic            mul_start, mul_load;
  logic [CW-1:0]   mul_cnt;
  logic [XLEN-1:0] mcand, mplier, acc, acc_step;
  logic [31:0]     m_ir;
  logic [XLEN-1:0] m_npc, m_store;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] alu_b, alu_res, target, jalr_sum, pc_next;
  logic [SHW-1:0]  shamt;
  logic            illegal, is_mul, taken, misalign, redir_c;
  logic            out_free, accept, load_alu;

  assign opcode = in_ir[6:0];
  assign funct3 = in_ir[14:12];
  assign funct7 = in_ir[31:25];

  assign out_free = !out_valid || out_ready;
  assign in_ready = rst_n && !flush && (state_q == S_IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign load_alu = accept && !is_mul;
  assign busy     = (state_q == S_MUL);

  // Decode, ALU and control-flow resolution for the instruction at the input.
  always_comb begin
    alu_b    = (opcode == OP_REG) ? in_b : in_imm;
    shamt    = alu_b[SHW-1:0];
    jalr_sum = in_a + in_imm;
    alu_res  = '0;
    target   = '0;
    illegal  = 1'b0;
    is_mul   = 1'b0;
    taken    = 1'b0;
    case (opcode)
      OP_IMM, OP_REG: begin
        case (funct3)
          3'b000:  alu_res = (opcode == OP_REG && funct7[5]) ? in_a - alu_b : in_a + alu_b;
          3'b001:  alu_res = in_a << shamt;
          3'b010:  alu_res = XLEN'($signed(in_a) < $signed(alu_b));
          3'b011:  alu_res = XLEN'(in_a < alu_b);
          3'b100:  alu_res = in_a ^ alu_b;
          3'b101:  alu_res = funct7[5] ? XLEN'($signed(in_a) >>> shamt) : in_a >> shamt;
          3'b110:  alu_res = in_a | alu_b;
          default: alu_res = in_a & alu_b;
        endcase
        if (opcode == OP_REG) begin
          if (funct7 == 7'b0000001) begin
            if (MUL_EN != 0 && funct3 == 3'b000) is_mul = 1'b1;
            else                                 illegal = 1'b1;
          end else if (funct7 != 7'b0000000 &&
                       !(funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
            illegal = 1'b1;
          end
        end else if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shift immediates: upper bits must encode SLLI/SRLI/SRAI only.
          if (in_ir[31:26] != 6'b000000 &&
              !(in_ir[31:26] == 6'b010000 && funct3 == 3'b101)) illegal = 1'b1;
          if (XLEN == 32 && in_ir[25]) illegal = 1'b1;
        end
      end
      OP_LOAD, OP_STORE: alu_res = in_a + in_imm;
      OP_LUI:            alu_res = in_imm;
      OP_AUIPC:          alu_res = in_pc + in_imm;
      OP_BRANCH: begin
        target = in_pc + in_imm;
        case (funct3)
          3'b000:  taken = (in_a == in_b);
          3'b001:  taken = (in_a != in_b);
          3'b100:  taken = ($signed(in_a) <  $signed(in_b));
          3'b101:  taken = ($signed(in_a) >= $signed(in_b));
          3'b110:  taken = (in_a <  in_b);
          3'b111:  taken = (in_a >= in_b);
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        target  = in_pc + in_imm;
        taken   = 1'b1;
        alu_res = in_npc;
      end
      OP_JALR: begin
        target  = jalr_sum & ~XLEN'(1);
        taken   = 1'b1;
        alu_res = in_npc;
        if (funct3 != 3'b000) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      alu_res = '0;
      taken   = 1'b0;
    end
    misalign = taken && target[1];
    redir_c  = taken && !misalign;
    pc_next  = redir_c ? target : in_npc;
  end

  // Multiplier control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    mul_load  = 1'b0;
    case (state_q)
      S_IDLE: if (accept && is_mul) begin
        state_d   = S_MUL;
        mul_start = 1'b1;
      end
      S_MUL:  if (mul_cnt == CW'(MUL_CYC - 1)) state_d = S_DONE;
      S_DONE: if (out_free) begin
        state_d  = S_IDLE;
        mul_load = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d   = S_IDLE;
      mul_start = 1'b0;
      mul_load  = 1'b0;
    end
  end

  // Shift-add step retiring MUL_BPC multiplier bits.
  always_comb begin
    acc_step = acc;
    for (int unsigned i = 0; i < MUL_BPC; i++) begin
      if (mplier[i]) acc_step = acc_step + (mcand << i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      mul_cnt <= '0;
      m_ir    <= '0;
      m_npc   <= '0;
      m_store <= '0;
    end else if (mul_start) begin
      mcand   <= in_a;
      mplier  <= in_b;
      acc     <= '0;
      mul_cnt <= '0;
      m_ir    <= in_ir;
      m_npc   <= in_npc;
      m_store <= in_b;
    end else if (state_q == S_MUL) begin
      acc     <= acc_step;
      mcand   <= mcand << MUL_BPC;
      mplier  <= mplier >> MUL_BPC;
      mul_cnt <= mul_cnt + CW'(1);
    end
  end

  // EX/MEM output register; redirect is only raised on the load edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_alu     <= '0;
      out_store   <= '0;
      out_ir      <= '0;
      out_pc_next <= '0;
      out_exc     <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      redirect  <= 1'b0;
    end else if (load_alu) begin
      out_valid   <= 1'b1;
      out_alu     <= alu_res;
      out_store   <= in_b;
      out_ir      <= in_ir;
      out_pc_next <= pc_next;
      out_exc     <= {misalign, illegal};
      redirect    <= redir_c;
      redirect_pc <= target;
    end else if (mul_load) begin
      out_valid   <= 1'b1;
      out_alu     <= acc;
      out_store   <= m_store;
      out_ir      <= m_ir;
      out_pc_next <= m_npc;
      out_exc     <= '0;
      redirect    <= 1'b0;
    end else begin
      redirect <= 1'b0;
      if (out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- Registered, parametrised execute stage for the RV32I core. It replaces the combinational execute path with an EX/MEM output register and valid/ready handshakes on both sides.
- Adds branch/jump resolution with a one-cycle redirect pulse, a synchronous flush, exception flags, and an iterative MUL unit under a small state machine.
- Sits between the ID/EX register and the memory stage.

Parameters:
- XLEN, 32: datapath width; must be 32 or 64.
- MUL_EN, 1: 1 implements MUL (opcode 0110011, funct7 0000001, funct3 000); 0 flags it illegal.
- MUL_BPC, 1: multiplier bits retired per cycle; must divide XLEN. MUL latency is XLEN/MUL_BPC cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX holds an instruction
- in_ready  out  1  stage accepts this cycle
- in_ir  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- in_npc  in  XLEN  PC+4
- in_a  in  XLEN  rs1 value
- in_b  in  XLEN  rs2 value
- in_imm  in  XLEN  sign-extended immediate
- flush  in  1  kill in-flight and registered work
- out_valid  out  1  EX/MEM register valid
- out_ready  in  1  memory stage consumes
- out_alu  out  XLEN  result, address, or link value
- out_store  out  XLEN  registered in_b (store data)
- out_ir  out  32  registered instruction
- out_pc_next  out  XLEN  resolved next PC
- out_exc  out  2  bit0 illegal opcode/funct, bit1 misaligned branch/jump target
- redirect  out  1  one-cycle pulse when control flow changes
- redirect_pc  out  XLEN  target PC for the redirect
- busy  out  1  multiplier running

Behaviour:
- Reset (rst_n low, asynchronous): all outputs and registers are 0; the state machine enters IDLE. in_ready is 0 during reset and becomes 1 in the first cycle after release.
- in_ready = (state==IDLE) && (!out_valid || out_ready). An instruction is accepted when in_valid && in_ready.
- Non-MUL instruction: the result is registered on the accept edge and out_valid=1 on the next edge (latency 1). Throughput is 1 per cycle while out_ready=1.
- Output hold: while out_valid && !out_ready, all out_* are held stable.
- ALU (funct3/funct7 per RV32I):
  - ADD/SUB: SUB only for R-type with funct7[5]=1.
  - SLL/SRL/SRA: shamt is the low $clog2(XLEN) bits of operand B; SRA/SRAI select on funct7[5].
  - SLT/SLTU, XOR, OR, AND.
  - Operand B = in_b for R-type, in_imm otherwise.
  - LOAD/STORE: out_alu = in_a+in_imm.
  - LUI: out_alu = in_imm.
  - AUIPC: out_alu = in_pc+in_imm.
- Branch (1100011):
  - funct3 BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111; funct3 010 and 011 are illegal.
  - Target = in_pc+in_imm. out_alu = 0.
- JAL: target = in_pc+in_imm. JALR: target = (in_a+in_imm) with bit0 cleared. For both, out_alu = in_npc.
- out_pc_next = target if the branch is taken or the instruction is a jump; otherwise in_npc.
- redirect is 1 for exactly the first cycle of out_valid, with redirect_pc = target. It is not re-asserted while output is held.
- Misaligned target (target[1]==1): out_exc[1]=1, redirect=0, out_pc_next=in_npc.
- Unknown opcode: out_exc[0]=1, out_alu=0, redirect=0. The instruction still flows to memory.
- MUL state machine:
  - IDLE -> MUL on accepting a MUL instruction. The operands, in_ir, in_npc and in_b are latched. busy=1 and in_ready=0.
  - MUL iterates a shift-add of MUL_BPC bits per cycle, producing the low XLEN bits of in_a*in_b; results are identical for signed and unsigned.
  - After XLEN/MUL_BPC cycles the state goes to DONE, which loads the output register when !out_valid || out_ready.
  - DONE -> IDLE in the cycle the output loads. out_pc_next = latched in_npc.
- Flush (synchronous, highest priority): on the next edge out_valid=0, redirect=0, the state machine returns to IDLE and busy=0. An instruction presented in the same cycle is not accepted: in_ready is forced to 0 while flush=1.
- Simultaneous out_ready and a new accept in the same cycle: the register is replaced with the new result (no bubble).
- Reset mid-MUL: the partial product is discarded and the stage enters IDLE.

Test Plan:
- ADD: in_ir R-type ADD, in_a=5, in_b=7, out_ready=1 -> next cycle out_valid=1, out_alu=12, out_pc_next=in_npc, redirect=0.
- Branch: BLT with in_a=-1 (FFFFFFFF), in_b=1, in_pc=0x100, in_imm=0x20 -> redirect pulse for 1 cycle, redirect_pc=0x120. BLTU with the same operands -> not taken, out_pc_next=0x104.
- JALR: in_a=0x203, in_imm=0, in_npc=0x44 -> out_alu=0x44, redirect_pc=0x202, out_exc[1]=1 (bit1 set), redirect=0.
- MUL: in_a=0x10001, in_b=0x3, MUL_BPC=1 -> busy for 32 cycles with in_ready=0, then out_alu=0x30003 and busy=0.
- Backpressure: hold out_ready=0 across three instructions -> the second instruction stalls with in_ready=0, out_* stay unchanged, and redirect does not repeat. Releasing out_ready drains the instructions in order with no bubble.
- Flush mid-MUL at cycle 10 -> out_valid stays 0, busy=0 on the next edge, and the next ADD completes normally. A separate run with rst_n pulsed mid-MUL -> all outputs 0 immediately.
